// File: rtl/div_ctrl.sv
// Sequencer for a restoring unsigned divider: steps the R:X:Y datapath through
// load, then WIDTH shift/test iterations, with a 4-phase go/done handshake.
module div_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic div_zero,
  input  logic r_lt_y,
  output logic ld_xy,
  output logic clr_r,
  output logic sl_rx,
  output logic ld_r,
  output logic set_q0,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    SHIFT = 3'd2,
    TEST  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             err_q_r, err_q_s;

  // State, iteration counter and divide-by-zero flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      err_q_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      err_q_r <= err_q_s;
    end
  end

  // Next-state logic and Moore decode of the datapath strobes
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    err_q_s = err_q_r;
    ld_xy   = 1'b0;
    clr_r   = 1'b0;
    sl_rx   = 1'b0;
    ld_r    = 1'b0;
    set_q0  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    case (state_r)
      IDLE: begin
        if (go) begin
          if (div_zero) begin
            state_s = DONE;
            err_q_s = 1'b1;
          end else begin
            state_s = INIT;
            err_q_s = 1'b0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      INIT: begin
        ld_xy   = 1'b1;
        clr_r   = 1'b1;
        busy    = 1'b1;
        cnt_s   = {CNT_W{1'b0}};
        state_s = SHIFT;
      end
      SHIFT: begin
        sl_rx   = 1'b1;
        busy    = 1'b1;
        state_s = TEST;
        // Saturate rather than wrap so a corrupted count can never run past WIDTH
        if (cnt_r != LAST_ITER) begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_s = cnt_r;
        end
      end
      TEST: begin
        busy = 1'b1;
        // Subtract and record the quotient bit together when R >= Y
        if (!r_lt_y) begin
          ld_r   = 1'b1;
          set_q0 = 1'b1;
        end else begin
          ld_r   = 1'b0;
          set_q0 = 1'b0;
        end
        if (cnt_r == LAST_ITER) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        done = 1'b1;
        err  = err_q_r;
        if (go) begin
          state_s = DONE;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl wrapped with a behavioural restoring-divider
// datapath (R:X:Y registers, subtractor, comparator) at WIDTH=4.
module tb_div_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic go = 1'b0;
  logic [3:0] dividend = 4'd0;
  logic [3:0] divisor = 4'd0;
  logic div_zero, r_lt_y;
  logic ld_xy, clr_r, sl_rx, ld_r, set_q0, busy, done, err;

  logic [4:0] r = 5'd0;
  logic [3:0] x = 4'd0;
  logic [3:0] y = 4'd0;

  int checks = 0;
  int errors = 0;

  int n_ld_xy = 0, n_sl_rx = 0, n_ld_r = 0, n_excl = 0, n_pair = 0;

  always #5 clk = ~clk;

  div_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .go(go), .div_zero(div_zero), .r_lt_y(r_lt_y),
    .ld_xy(ld_xy), .clr_r(clr_r), .sl_rx(sl_rx), .ld_r(ld_r), .set_q0(set_q0),
    .busy(busy), .done(done), .err(err)
  );

  assign div_zero = (divisor == 4'd0);
  assign r_lt_y   = (r < {1'b0, y});

  // Behavioural datapath driven by the controller strobes
  always @(posedge clk) begin
    if (ld_xy) begin
      x <= dividend;
      y <= divisor;
    end
    if (clr_r) r <= 5'd0;
    if (sl_rx) begin
      r <= {r[3:0], x[3]};
      x <= {x[2:0], 1'b0};
    end
    if (ld_r) r <= r - {1'b0, y};
    if (set_q0) x[0] <= 1'b1;
  end

  // Cumulative strobe counters and rule-violation counters
  always @(negedge clk) begin
    if (rst) begin
      if (ld_xy) n_ld_xy++;
      if (sl_rx) n_sl_rx++;
      if (ld_r)  n_ld_r++;
      if ((int'(ld_xy) + int'(sl_rx) + int'(ld_r)) > 1) n_excl++;
      if (ld_r != set_q0) n_pair++;
    end
  end

  // Starts an op at a negedge; returns negedges until done seen (61 = timeout)
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit hold,
                        output int lat, output int busy_gaps);
    dividend = a;
    divisor  = b;
    go       = 1'b1;
    lat      = 0;
    busy_gaps = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!hold) go = 1'b0;
      if (!done && !busy) busy_gaps++;
    end while (!done && lat < 61);
  endtask

  // Drops go and expects IDLE after one edge
  task automatic end_op(input string name);
    go = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: done=%b busy=%b, required done=0 busy=0", name, done, busy);
    end
  endtask

  task automatic check_result(input string name, input int lat, input int exp_lat,
                              input logic [3:0] exp_q, input logic [4:0] exp_r, input logic exp_err);
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d, required %0d", name, lat, exp_lat);
    end
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL %s_err: got %b, required %b", name, err, exp_err);
    end
    if (!exp_err) begin
      checks++;
      if (x !== exp_q || r !== exp_r) begin
        errors++;
        $display("FAIL %s_result: X=%0d R=%0d, required X=%0d R=%0d", name, x, r, exp_q, exp_r);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ld_xy, clr_r, sl_rx, ld_r, set_q0, busy, done, err} !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 00000000",
               {ld_xy, clr_r, sl_rx, ld_r, set_q0, busy, done, err});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, gaps;
    run_op(4'd13, 4'd3, 1'b0, lat, gaps);
    // Sampling edge counts as edge 1; done appears after edge 10
    check_result("div13_3", lat, 10, 4'd4, 5'd1, 1'b0);
    checks++;
    if (gaps !== 0) begin
      errors++;
      $display("FAIL div13_3_busy: %0d cycles without busy, required 0", gaps);
    end
    end_op("div13_3");
  endtask

  task automatic test_div_zero();
    int lat, gaps;
    int sx = n_ld_xy, ss = n_sl_rx, sr = n_ld_r;
    run_op(4'd7, 4'd0, 1'b0, lat, gaps);
    check_result("div7_0", lat, 1, 4'd0, 5'd0, 1'b1);
    end_op("div7_0");
    checks++;
    if (n_ld_xy != sx || n_sl_rx != ss || n_ld_r != sr) begin
      errors++;
      $display("FAIL div7_0_strobes: ld_xy=%0d sl_rx=%0d ld_r=%0d, required 0 0 0",
               n_ld_xy - sx, n_sl_rx - ss, n_ld_r - sr);
    end
  endtask

  task automatic test_small_and_full();
    int lat, gaps, sr;
    sr = n_ld_r;
    run_op(4'd3, 4'd7, 1'b0, lat, gaps);
    check_result("div3_7", lat, 10, 4'd0, 5'd3, 1'b0);
    checks++;
    if (n_ld_r - sr != 0) begin
      errors++;
      $display("FAIL div3_7_ldr: got %0d, required 0", n_ld_r - sr);
    end
    end_op("div3_7");
    sr = n_ld_r;
    run_op(4'd15, 4'd1, 1'b0, lat, gaps);
    check_result("div15_1", lat, 10, 4'd15, 5'd0, 1'b0);
    checks++;
    if (n_ld_r - sr != 4) begin
      errors++;
      $display("FAIL div15_1_ldr: got %0d, required 4", n_ld_r - sr);
    end
    end_op("div15_1");
  endtask

  task automatic test_hold_go();
    int lat, gaps, sx, bad;
    run_op(4'd10, 4'd3, 1'b1, lat, gaps);
    check_result("hold10_3", lat, 10, 4'd3, 5'd1, 1'b0);
    sx = n_ld_xy;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (done !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || n_ld_xy != sx) begin
      errors++;
      $display("FAIL hold_done: %0d cycles left DONE, %0d extra INITs, required 0 0", bad, n_ld_xy - sx);
    end
    end_op("hold");
  endtask

  task automatic test_async_reset();
    int lat, gaps;
    dividend = 4'd13;
    divisor  = 4'd3;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sl_rx !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midop_shift: sl_rx=%b busy=%b, required 1 1", sl_rx, busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({ld_xy, clr_r, sl_rx, ld_r, set_q0, busy, done, err} !== 8'd0) begin
      errors++;
      $display("FAIL midop_reset: got %b, required 00000000",
               {ld_xy, clr_r, sl_rx, ld_r, set_q0, busy, done, err});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op(4'd9, 4'd2, 1'b0, lat, gaps);
    check_result("div9_2", lat, 10, 4'd4, 5'd1, 1'b0);
    end_op("div9_2");
  endtask

  task automatic test_exhaustive();
    int lat, gaps, ex, pr;
    logic [3:0] qa, qb;
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        qa = 4'(a);
        qb = 4'(b);
        ex = n_excl;
        pr = n_pair;
        run_op(qa, qb, 1'b0, lat, gaps);
        check_result("exh", lat, 10, 4'(a / b), 5'(a % b), 1'b0);
        checks++;
        if (n_excl != ex || n_pair != pr) begin
          errors++;
          $display("FAIL exh_strobes %0d/%0d: excl=%0d pair=%0d, required 0 0",
                   a, b, n_excl - ex, n_pair - pr);
        end
        go = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_div_zero();
    test_basic();
    test_small_and_full();
    test_hold_go();
    test_async_reset();
    test_exhaustive();
    checks++;
    if (n_excl != 0 || n_pair != 0) begin
      errors++;
      $display("FAIL strobe_rules: excl=%0d pair=%0d, required 0 0", n_excl, n_pair);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
